// File: rtl/song_sequencer_pkg.sv
// Shared song sequencer constants: note codes, end-of-song marker, ROM entry layout and FSM states.
package song_sequencer_pkg;

    localparam logic [3:0] NOTE_NONE = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_D    = 4'd2;
    localparam logic [3:0] NOTE_E    = 4'd3;
    localparam logic [3:0] NOTE_F    = 4'd4;
    localparam logic [3:0] NOTE_G    = 4'd5;
    localparam logic [3:0] NOTE_A    = 4'd6;
    localparam logic [3:0] NOTE_B    = 4'd7;
    localparam logic [3:0] NOTE_C5   = 4'd8;

    localparam logic [3:0] DUR_END   = 4'd0;

    typedef struct packed {
        logic [3:0] note;
        logic [3:0] dur;
    } rom_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_ROM = 3'd2,
        ST_PLAY     = 3'd3,
        ST_GAP      = 3'd4,
        ST_PAUSED   = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    // Codes above C5 are rests: silent, but their duration still counts.
    function automatic logic [3:0] play_code(input logic [3:0] code);
        return (code > NOTE_C5) ? NOTE_NONE : code;
    endfunction

endpackage

// File: rtl/song_sequencer_beat_counter.sv
// 4-bit loadable down-counter used for note durations and inter-note gaps.
module song_sequencer_beat_counter (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       zero_c
);

    logic [3:0] cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero_c = (cnt == 4'd0);

endmodule

// File: rtl/song_sequencer.sv
// ROM-driven song player: walks note entries, holds each for dur TICKs, with optional silent gaps.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned GAP_TICKS = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              TICK,
    input  logic              START,
    input  logic              STOP,
    input  logic              PAUSE,
    input  logic              LOOP,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [3:0]        note,
    output logic [7:0]        Led,
    output logic              busy,
    output logic              done
);

    // Counter holds remaining ticks minus one, so the TICK seen at zero is the final one.
    localparam logic [3:0] GAP_LOAD = (GAP_TICKS != 0) ? 4'(GAP_TICKS - 1) : 4'd0;

    state_t            state, state_d;
    rom_entry_t        entry;
    logic [ADDR_W-1:0] addr_d;
    logic [3:0]        note_d, cur_note, cur_d;
    logic [7:0]        led_d;
    logic              resume_gap, resume_d;
    logic              wrap, wrap_d;
    logic              cnt_load, cnt_en, cnt_zero;
    logic [3:0]        cnt_val;

    assign entry = rom_data;

    song_sequencer_beat_counter u_beat_counter (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .zero_c   (cnt_zero)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            rom_addr   <= '0;
            note       <= NOTE_NONE;
            Led        <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            cur_note   <= NOTE_NONE;
            resume_gap <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            state      <= state_d;
            rom_addr   <= addr_d;
            note       <= note_d;
            Led        <= led_d;
            busy       <= (state_d != ST_IDLE);
            done       <= (state_d == ST_DONE);
            cur_note   <= cur_d;
            resume_gap <= resume_d;
            wrap       <= wrap_d;
        end
    end

    // Next-state logic; STOP outranks PAUSE, which outranks (and swallows) TICK.
    always_comb begin
        state_d  = state;
        addr_d   = rom_addr;
        note_d   = note;
        cur_d    = cur_note;
        resume_d = resume_gap;
        wrap_d   = wrap;
        cnt_load = 1'b0;
        cnt_val  = 4'd0;
        cnt_en   = 1'b0;

        if (STOP) begin
            state_d  = ST_IDLE;
            addr_d   = '0;
            note_d   = NOTE_NONE;
            wrap_d   = 1'b0;
            cnt_load = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    addr_d = '0;
                    note_d = NOTE_NONE;
                    if (START) state_d = ST_FETCH;
                end
                ST_FETCH: state_d = ST_WAIT_ROM;
                ST_WAIT_ROM: begin
                    if (entry.dur == DUR_END || wrap) begin
                        wrap_d = 1'b0;
                        addr_d = '0;
                        if (LOOP) begin
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_DONE;
                            note_d  = NOTE_NONE;
                        end
                    end else begin
                        state_d  = ST_PLAY;
                        cur_d    = play_code(entry.note);
                        note_d   = play_code(entry.note);
                        cnt_load = 1'b1;
                        cnt_val  = entry.dur - 4'd1;
                    end
                end
                ST_PLAY: begin
                    if (PAUSE) begin
                        state_d  = ST_PAUSED;
                        resume_d = 1'b0;
                        note_d   = NOTE_NONE;
                    end else if (TICK) begin
                        if (!cnt_zero) begin
                            cnt_en = 1'b1;
                        end else if (GAP_TICKS != 0) begin
                            state_d  = ST_GAP;
                            note_d   = NOTE_NONE;
                            cnt_load = 1'b1;
                            cnt_val  = GAP_LOAD;
                        end else begin
                            state_d = ST_FETCH;
                            addr_d  = rom_addr + ADDR_W'(1);
                            wrap_d  = (rom_addr == '1);
                        end
                    end
                end
                ST_GAP: begin
                    note_d = NOTE_NONE;
                    if (PAUSE) begin
                        state_d  = ST_PAUSED;
                        resume_d = 1'b1;
                    end else if (TICK) begin
                        if (!cnt_zero) begin
                            cnt_en = 1'b1;
                        end else begin
                            state_d = ST_FETCH;
                            addr_d  = rom_addr + ADDR_W'(1);
                            wrap_d  = (rom_addr == '1);
                        end
                    end
                end
                ST_PAUSED: begin
                    note_d = NOTE_NONE;
                    if (PAUSE) begin
                        if (resume_gap) begin
                            state_d = ST_GAP;
                        end else begin
                            state_d = ST_PLAY;
                            note_d  = cur_note;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    note_d  = NOTE_NONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                    note_d  = NOTE_NONE;
                end
            endcase
        end
    end

    // LED image tracks the next note so both registers switch on the same edge.
    always_comb begin
        led_d = 8'h00;
        case (note_d)
            NOTE_C4: led_d = 8'h80;
            NOTE_D:  led_d = 8'h40;
            NOTE_E:  led_d = 8'h20;
            NOTE_F:  led_d = 8'h10;
            NOTE_G:  led_d = 8'h08;
            NOTE_A:  led_d = 8'h04;
            NOTE_B:  led_d = 8'h02;
            NOTE_C5: led_d = 8'h01;
            default: led_d = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: playback, gaps, loop, pause, stop, address wrap and async reset.
module tb_song_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       TICK, START, STOP, PAUSE, LOOP;
    logic [4:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] note;
    logic [7:0] Led;
    logic       busy, done;

    logic [7:0] rom [32];
    int         n_cmp = 0;
    int         n_bad = 0;

    song_sequencer #(.ADDR_W(5), .GAP_TICKS(1)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .TICK     (TICK),
        .START    (START),
        .STOP     (STOP),
        .PAUSE    (PAUSE),
        .LOOP     (LOOP),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .note     (note),
        .Led      (Led),
        .busy     (busy),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic tick();
        TICK = 1'b1;
        cyc();
        TICK = 1'b0;
    endtask

    task automatic start_song();
        START = 1'b1;
        cyc();
        START = 1'b0;
        idle(2);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] n, input logic [7:0] l);
        chk({tag, ".note"}, 32'(note), 32'(n));
        chk({tag, ".led"}, 32'(Led), 32'(l));
    endtask

    initial begin
        logic [3:0] code;
        logic [3:0] exp_n;
        logic [7:0] exp_l;

        RESET = 1'b1;
        {TICK, START, STOP, PAUSE, LOOP} = '0;
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[0] = 8'h12;
        rom[1] = 8'h31;
        rom[2] = 8'h00;
        #12;
        chk_out("reset", 4'd0, 8'h00);
        chk("reset.addr", 32'(rom_addr), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        RESET = 1'b0;
        cyc();

        // C4/2, E/1, end with one-tick gaps, no loop
        START = 1'b1;
        cyc();
        START = 1'b0;
        chk("t1.busy_rise", 32'(busy), 32'd1);
        chk("t1.fetch_note", 32'(note), 32'd0);
        idle(2);
        chk_out("t1.c4", 4'd1, 8'h80);
        tick();
        chk_out("t1.c4_tick1", 4'd1, 8'h80);
        idle(3);
        tick();
        chk_out("t1.gap1", 4'd0, 8'h00);
        idle(3);
        tick();
        chk("t1.addr1", 32'(rom_addr), 32'd1);
        idle(3);
        chk_out("t1.e", 4'd3, 8'h20);
        tick();
        chk_out("t1.gap2", 4'd0, 8'h00);
        idle(3);
        tick();
        chk("t1.addr2", 32'(rom_addr), 32'd2);
        idle(2);
        chk("t1.done", 32'(done), 32'd1);
        chk("t1.busy_at_done", 32'(busy), 32'd1);
        cyc();
        chk("t1.done_clr", 32'(done), 32'd0);
        chk("t1.busy_fall", 32'(busy), 32'd0);

        // Same song looping; then STOP together with PAUSE and TICK
        LOOP = 1'b1;
        start_song();
        chk_out("t2.c4", 4'd1, 8'h80);
        tick(); idle(3);
        tick(); idle(3);
        tick(); idle(3);
        chk_out("t2.e", 4'd3, 8'h20);
        tick(); idle(3);
        tick();
        cyc();
        cyc();
        chk("t2.loop_addr", 32'(rom_addr), 32'd0);
        chk("t2.loop_nodone", 32'(done), 32'd0);
        chk("t2.loop_busy", 32'(busy), 32'd1);
        cyc();
        cyc();
        chk_out("t2.c4_again", 4'd1, 8'h80);
        chk("t2.nodone2", 32'(done), 32'd0);
        tick();
        {STOP, PAUSE, TICK} = 3'b111;
        cyc();
        {STOP, PAUSE, TICK} = 3'b000;
        LOOP = 1'b0;
        chk_out("t4.stop", 4'd0, 8'h00);
        chk("t4.stop_addr", 32'(rom_addr), 32'd0);
        chk("t4.stop_busy", 32'(busy), 32'd0);
        start_song();
        chk_out("t4.replay", 4'd1, 8'h80);
        chk("t4.replay_addr", 32'(rom_addr), 32'd0);
        STOP = 1'b1;
        cyc();
        STOP = 1'b0;

        // Pause during C4/4: ticks while paused are ignored, then 3 remaining ticks
        rom[0] = 8'h14;
        rom[1] = 8'h00;
        start_song();
        chk_out("t3.c4", 4'd1, 8'h80);
        tick(); idle(3);
        PAUSE = 1'b1;
        cyc();
        PAUSE = 1'b0;
        chk_out("t3.paused", 4'd0, 8'h00);
        chk("t3.paused_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick(); idle(3);
        end
        chk_out("t3.still_paused", 4'd0, 8'h00);
        PAUSE = 1'b1;
        cyc();
        PAUSE = 1'b0;
        chk_out("t3.resume", 4'd1, 8'h80);
        idle(3);
        tick();
        chk_out("t3.rem2", 4'd1, 8'h80);
        idle(3);
        tick();
        chk_out("t3.rem1", 4'd1, 8'h80);
        idle(3);
        tick();
        chk_out("t3.end", 4'd0, 8'h00);
        idle(3);
        tick();
        idle(2);
        chk("t3.done", 32'(done), 32'd1);
        cyc();

        // 32 entries with no end marker: wrap from 31 to 0 ends the song
        for (int i = 0; i < 32; i++) rom[i] = 8'h11;
        rom[5] = 8'h91;
        rom[6] = 8'h81;
        rom[9] = 8'h51;
        start_song();
        for (int i = 0; i < 32; i++) begin
            code  = rom[i][7:4];
            exp_n = (code > 4'd8) ? 4'd0 : code;
            exp_l = (exp_n == 4'd0) ? 8'h00 : (8'h80 >> (exp_n - 4'd1));
            chk_out($sformatf("t5.entry%0d", i), exp_n, exp_l);
            tick(); idle(3);
            tick();
            if (i == 31) chk("t5.wrap_addr", 32'(rom_addr), 32'd0);
            idle(2);
        end
        chk("t5.done", 32'(done), 32'd1);
        cyc();
        chk("t5.done_once", 32'(done), 32'd0);
        chk("t5.busy_fall", 32'(busy), 32'd0);

        // Async reset mid-note, released between edges; ticks afterwards stay in IDLE
        rom[0] = 8'h14;
        start_song();
        tick();
        chk_out("t6.playing", 4'd1, 8'h80);
        #3 RESET = 1'b1;
        #1;
        chk_out("t6.async", 4'd0, 8'h00);
        chk("t6.async_busy", 32'(busy), 32'd0);
        chk("t6.async_addr", 32'(rom_addr), 32'd0);
        #1 RESET = 1'b0;
        cyc();
        tick(); idle(3);
        tick(); idle(3);
        chk_out("t6.idle", 4'd0, 8'h00);
        chk("t6.idle_busy", 32'(busy), 32'd0);
        chk("t6.idle_addr", 32'(rom_addr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Programmable song sequencer for the FPGA piano. On command it walks a note ROM one entry at a time and holds each note for that entry's duration, counted in beat ticks from the clock manager. An optional silent gap separates consecutive notes. It produces the current note code and its one-hot LED image, which feed the existing tone-select, LED and segment-display datapath. It replaces per-song hard-coded autoplay logic: songs become ROM contents, and this block owns play, pause, stop and loop control of the shared tone output.

## Interface

Parameters:
- ADDR_W, 5: ROM address width. Song holds at most 2^ADDR_W entries.
- GAP_TICKS, 1: silent ticks inserted after every note. 0 means legato, with no gap.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high.
- TICK  in  1  one-cycle pulse per eighth-beat, synchronous to CLK.
- START  in  1  one-cycle pulse: begin the song at entry 0.
- STOP  in  1  one-cycle pulse: abort and return to idle.
- PAUSE  in  1  one-cycle pulse: toggle pause and resume.
- LOOP  in  1  level: restart at entry 0 when the end of song is reached.
- rom_addr  out  ADDR_W  ROM read address, registered.
- rom_data  in  8  {note[7:4], dur[3:0]}, valid one cycle after rom_addr.
- note  out  4  current note code, registered.
- Led  out  8  one-hot image of note, registered.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of song when LOOP=0.

## Operation

- Note codes: NONE=0, C4=1, D=2, E=3, F=4, G=5, A=6, B=7, C5=8.
- Codes 9–15 are played as rests. note=NONE, but the duration is still counted.
- Led: note k in 1..8 drives Led[8-k] high, so C4 maps to Led[7] and C5 to Led[0]. Any other code gives Led=0.
- An entry with dur=0 is the end-of-song marker.
- After address 2^ADDR_W−1 the address wraps to 0 and the block then behaves as if it had read an end-of-song marker.

States and transitions:
- IDLE: note=NONE, rom_addr=0. START moves to FETCH.
- FETCH: rom_addr is stable. Unconditionally moves to WAIT_ROM.
- WAIT_ROM: captures rom_data. On dur=0: go to FETCH at addr 0 if LOOP=1, otherwise go to DONE. Otherwise go to PLAY, load dur into the beat counter and register note.
- PLAY: each TICK decrements the counter. The TICK that reaches 0 moves to GAP (GAP_TICKS>0) or to FETCH at addr+1 (GAP_TICKS=0).
- GAP: note=NONE. After GAP_TICKS TICKs, moves to FETCH at addr+1.
- PAUSED: note=NONE, counter and address frozen. PAUSE returns to the saved state, PLAY or GAP. On resuming to PLAY, the saved note is restored.
- DONE: done=1 for this single cycle. Moves to IDLE.

Priority and event rules:
- Priority when events coincide: STOP, then PAUSE, then TICK.
- STOP in any state moves to IDLE on the next cycle, with note=NONE and rom_addr=0.
- PAUSE is ignored outside PLAY, GAP and PAUSED.
- A TICK that coincides with PAUSE is discarded.
- START is ignored unless the state is IDLE.
- TICK is ignored in FETCH, WAIT_ROM, IDLE, PAUSED and DONE.

## Timing

- Reset values: rom_addr=0, note=0, Led=0, busy=0, done=0, state IDLE, counter 0.
- With START sampled at cycle 0: FETCH in cycle 1, WAIT_ROM in cycle 2, and note/Led valid from cycle 3.
- Note duration is exactly dur TICK pulses. note changes on the cycle after the final TICK is sampled.
- Fetch overhead is 2 cycles. It is absorbed before the next TICK provided TICK spacing is at least 3 cycles, which is required of the environment.
- note and Led always change on the same edge.
- busy rises the cycle after START and falls the cycle after done.

## Structure

- Shared constants belong in the project parameters include: note codes, the dur=0 end marker and the state encodings. They are shared with the tone-select and display logic.
- One sub-module, beat_counter: a 4-bit loadable down-counter with load, TICK enable, hold and a zero flag. It is reused for both PLAY durations and GAP counting.
- The LED decode is an in-line registered case inside song_sequencer.

## Test plan

- ROM {C4/2, E/1, end}, GAP_TICKS=1, LOOP=0, START: the sequence is note=1 for 2 ticks, NONE for 1, note=3 for 1 tick, NONE for 1, then a done pulse and busy=0. Led goes 0x80, then 0x00, then 0x20.
- The same ROM with LOOP=1: after the end marker, note=1 reappears 3 cycles after the end-marker fetch. done never pulses.
- Pause: PAUSE pulsed during C4/4 after 1 tick gives note=NONE. Then 5 ticks and PAUSE again: C4 resumes and plays exactly 3 more ticks.
- STOP asserted together with PAUSE and TICK in PLAY: the next cycle is IDLE with note=0, rom_addr=0 and busy=0. A following START replays from entry 0.
- Full 32-entry ROM with no end marker, LOOP=0: the address wraps from 31 to 0, which is treated as end of song, so done pulses once.
- RESET asserted mid-note, asynchronously between edges: all outputs go to 0 immediately. TICKs applied after release keep the block in IDLE.
